rr_struct_arbiter: RTL

- Round-robin arbiter and burst sequencer that shares one downstream write port among N_REQ requesters.
- The port carries a packed record: a (10 b), aa (10 b), aaa (32 b unsigned).
- A 2-bit enumerated FSM grants one requester at a time for a burst, forwards its records, then rotates priority.
- Sits between the record producers and the single record sink (register file or bus bridge).

---
 rtl/rr_struct_arbiter_if.sv | 32 +++
 rtl/rr_struct_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rr_struct_arbiter_if.sv
// Request/grant bundle between N_REQ record producers, the arbiter and one record sink.
// The arbiter takes the slave view; producers and sink together drive the master view.
interface rr_struct_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ-1:0]    i_req_last;
  logic [N_REQ*10-1:0] i_req_a;
  logic [N_REQ*10-1:0] i_req_aa;
  logic [N_REQ*32-1:0] i_req_aaa;
  logic [N_REQ-1:0]    o_req_ready;

  logic                o_gnt_valid;
  logic                i_gnt_ready;
  logic [9:0]          o_gnt_a;
  logic [9:0]          o_gnt_aa;
  logic [31:0]         o_gnt_aaa;
  logic [ID_W-1:0]     o_gnt_id;
  logic                o_busy;

  modport slave (
    input  i_req_valid, i_req_last, i_req_a, i_req_aa, i_req_aaa, i_gnt_ready,
    output o_req_ready, o_gnt_valid, o_gnt_a, o_gnt_aa, o_gnt_aaa, o_gnt_id, o_busy
  );

  modport master (
    output i_req_valid, i_req_last, i_req_a, i_req_aa, i_req_aaa, i_gnt_ready,
    input  o_req_ready, o_gnt_valid, o_gnt_a, o_gnt_aa, o_gnt_aaa, o_gnt_id, o_busy
  );
endinterface

// File: rtl/rr_struct_arbiter.sv
// Round-robin arbiter and burst sequencer: one requester owns the sink port per grant,
// bursts end on last, beat limit or stall timeout, then priority rotates past the owner.
module rr_struct_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 8,
  parameter int STALL_MAX = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  rr_struct_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic [9:0]  a;
    logic [9:0]  aa;
    logic [31:0] aaa;
  } rec_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] r_last_winner;
  logic [7:0]      r_beat_cnt;
  logic [7:0]      r_stall_cnt;

  logic [ID_W-1:0] w_pick;
  logic            w_found;
  int              w_idx;
  rec_t            w_owner_rec;
  logic            w_owner_valid;
  logic            w_owner_last;
  logic            w_xfer;
  logic [7:0]      w_beat_inc;
  logic [7:0]      w_stall_inc;

  // Rotating priority: first valid requester strictly after the previous winner.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = int'(r_last_winner) + 1 + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && bus.i_req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_owner_rec.a   = bus.i_req_a[int'(r_owner)*10 +: 10];
    w_owner_rec.aa  = bus.i_req_aa[int'(r_owner)*10 +: 10];
    w_owner_rec.aaa = bus.i_req_aaa[int'(r_owner)*32 +: 32];
    w_owner_valid   = bus.i_req_valid[r_owner];
    w_owner_last    = bus.i_req_last[r_owner];
    w_xfer          = (r_state == ST_GRANT) && w_owner_valid && bus.i_gnt_ready;
    w_beat_inc      = r_beat_cnt + 8'd1;
    w_stall_inc     = r_stall_cnt + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (w_xfer && (w_owner_last || w_beat_inc == 8'(MAX_BEATS))) begin
          w_state_nxt = ST_RELEASE;
        end else if (!w_owner_valid && w_stall_inc == 8'(STALL_MAX)) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Backpressure from the sink is not a stall: only a missing owner record counts.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_owner       <= '0;
      r_last_winner <= ID_W'(N_REQ - 1);
      r_beat_cnt    <= '0;
      r_stall_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner     <= w_pick;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_xfer) begin
            r_beat_cnt  <= w_beat_inc;
            r_stall_cnt <= '0;
          end else if (!w_owner_valid) begin
            r_stall_cnt <= w_stall_inc;
          end
        end
        ST_RELEASE: r_last_winner <= r_owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_req_ready = '0;
    bus.o_gnt_valid = 1'b0;
    bus.o_gnt_a     = '0;
    bus.o_gnt_aa    = '0;
    bus.o_gnt_aaa   = '0;
    bus.o_gnt_id    = '0;
    bus.o_busy      = (r_state == ST_GRANT) || (r_state == ST_RELEASE);
    if (r_state == ST_GRANT) begin
      bus.o_req_ready[r_owner] = bus.i_gnt_ready;
      bus.o_gnt_valid          = w_owner_valid;
      bus.o_gnt_a              = w_owner_rec.a;
      bus.o_gnt_aa             = w_owner_rec.aa;
      bus.o_gnt_aaa            = w_owner_rec.aaa;
      bus.o_gnt_id             = r_owner;
    end
  end
endmodule
